// File: rtl/dmi_debug_module.sv
// Minimal RISC-V style Debug Module sitting behind a DTM's DMI initiator.
// Decodes data0/dmcontrol/dmstatus/abstractcs/command, drives halt/resume
// requests, and runs abstract register-access commands over a req/ack port.
module dmi_debug_module #(
    parameter int ABITS       = 7,
    parameter int DM_VERSION  = 2,
    parameter int REG_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ABITS-1:0] dmi_addr,
    input  logic [31:0]      dmi_wdata,
    input  logic [1:0]       dmi_op,
    input  logic             dmi_req,
    output logic [31:0]      dmi_rdata,
    output logic [1:0]       dmi_resp,
    output logic             dmi_ack,
    input  logic             halted,
    output logic             halt_req,
    output logic             resume_req,
    output logic             reg_req,
    output logic             reg_we,
    output logic [15:0]      reg_addr,
    output logic [31:0]      reg_wdata,
    input  logic [31:0]      reg_rdata,
    input  logic             reg_ack
);

    localparam logic [ABITS-1:0] ADDR_DATA0      = ABITS'('h04);
    localparam logic [ABITS-1:0] ADDR_DMCONTROL  = ABITS'('h10);
    localparam logic [ABITS-1:0] ADDR_DMSTATUS   = ABITS'('h11);
    localparam logic [ABITS-1:0] ADDR_ABSTRACTCS = ABITS'('h16);
    localparam logic [ABITS-1:0] ADDR_COMMAND    = ABITS'('h17);

    localparam logic [1:0] OP_READ  = 2'd1;
    localparam logic [1:0] OP_WRITE = 2'd2;
    localparam logic [1:0] OP_RSVD  = 2'd3;

    localparam int            TW       = $clog2(REG_TIMEOUT + 1);
    localparam logic [TW-1:0] CNT_LAST = TW'(REG_TIMEOUT - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_e;

    state_e        state_q, state_d;
    logic          dmi_ack_q, dmi_ack_d;
    logic [31:0]   dmi_rdata_q, dmi_rdata_d;
    logic [1:0]    dmi_resp_q, dmi_resp_d;
    logic [31:0]   data0_q, data0_d;
    logic          haltreq_q, haltreq_d;
    logic          ndmreset_q, ndmreset_d;
    logic          dmactive_q, dmactive_d;
    logic          resume_req_q, resume_req_d;
    logic          resumeack_q, resumeack_d;
    logic [2:0]    cmderr_q, cmderr_d;
    logic          cmd_write_q, cmd_write_d;
    logic [15:0]   cmd_regno_q, cmd_regno_d;
    logic          reg_req_q, reg_req_d;
    logic          reg_we_q, reg_we_d;
    logic [15:0]   reg_addr_q, reg_addr_d;
    logic [31:0]   reg_wdata_q, reg_wdata_d;
    logic [TW-1:0] cnt_q, cnt_d;

    logic          busy;
    logic [31:0]   rdata_mux;

    assign busy = (state_q != ST_IDLE);

    // Read-side register view, captured into dmi_rdata when a read is accepted
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        rdata_mux = 32'd0;
        case (dmi_addr)
            ADDR_DATA0:      rdata_mux = data0_q;
            ADDR_DMCONTROL:  rdata_mux = {haltreq_q, 1'b0, 28'd0, ndmreset_q, dmactive_q};
            ADDR_DMSTATUS:   rdata_mux = {14'd0, resumeack_q, resumeack_q, 4'd0,
                                          ~halted, ~halted, halted, halted,
                                          1'b1, 3'd0, 4'(DM_VERSION)};
            ADDR_ABSTRACTCS: rdata_mux = {3'd0, 5'd0, 11'd0, busy, 1'b0, cmderr_q, 4'd0, 4'd1};
            default:         rdata_mux = 32'd0;
        endcase
    end

    // Next-state: resume handshake, abstract FSM, DMI decode, then dmactive override
    always_comb begin
        state_d      = state_q;
        dmi_ack_d    = 1'b0;
        dmi_rdata_d  = dmi_rdata_q;
        dmi_resp_d   = dmi_resp_q;
        data0_d      = data0_q;
        haltreq_d    = haltreq_q;
        ndmreset_d   = ndmreset_q;
        dmactive_d   = dmactive_q;
        resume_req_d = resume_req_q;
        resumeack_d  = resumeack_q;
        cmderr_d     = cmderr_q;
        cmd_write_d  = cmd_write_q;
        cmd_regno_d  = cmd_regno_q;
        reg_req_d    = reg_req_q;
        reg_we_d     = reg_we_q;
        reg_addr_d   = reg_addr_q;
        reg_wdata_d  = reg_wdata_q;
        cnt_d        = cnt_q;

        // The CPU has left halt: retire the resume request and report it.
        if (resume_req_q && !halted) begin
            resume_req_d = 1'b0;
            resumeack_d  = 1'b1;
        end

        case (state_q)
            ST_ISSUE: begin
                reg_req_d   = 1'b1;
                reg_we_d    = cmd_write_q;
                reg_addr_d  = cmd_regno_q;
                reg_wdata_d = data0_q;
                cnt_d       = '0;
                state_d     = ST_WAIT;
            end
            ST_WAIT: begin
                if (reg_ack) begin
                    reg_req_d = 1'b0;
                    if (!reg_we_q) data0_d = reg_rdata;
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    reg_req_d = 1'b0;
                    cmderr_d  = 3'd7;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            default: ;
        endcase

        if (dmi_req && !dmi_ack_q) begin
            dmi_ack_d  = 1'b1;
            dmi_resp_d = (dmi_op == OP_RSVD) ? 2'b10 : 2'b00;
            if (dmi_op == OP_READ) dmi_rdata_d = rdata_mux;
            if (dmi_op == OP_WRITE) begin
                case (dmi_addr)
                    ADDR_DATA0: begin
                        if (busy) begin
                            if (cmderr_d == 3'd0) cmderr_d = 3'd1;
                        end else begin
                            data0_d = dmi_wdata;
                        end
                    end
                    ADDR_DMCONTROL: begin
                        dmactive_d = dmi_wdata[0];
                        ndmreset_d = dmi_wdata[1];
                        haltreq_d  = dmi_wdata[31];
                        if (dmi_wdata[30] && !dmi_wdata[31]) begin
                            resume_req_d = 1'b1;
                            resumeack_d  = 1'b0;
                        end
                    end
                    ADDR_ABSTRACTCS: begin
                        if (busy) begin
                            if (cmderr_d == 3'd0) cmderr_d = 3'd1;
                        end else begin
                            cmderr_d = cmderr_d & ~dmi_wdata[10:8];
                        end
                    end
                    ADDR_COMMAND: begin
                        if (busy) begin
                            if (cmderr_d == 3'd0) cmderr_d = 3'd1;
                        end else if (cmderr_q != 3'd0) begin
                            // Sticky error blocks new commands until cleared.
                        end else if (dmi_wdata[31:24] != 8'd0 || dmi_wdata[22:20] != 3'd2) begin
                            cmderr_d = 3'd2;
                        end else if (dmi_wdata[17] && !halted) begin
                            cmderr_d = 3'd4;
                        end else if (dmi_wdata[17]) begin
                            cmd_write_d = dmi_wdata[16];
                            cmd_regno_d = dmi_wdata[15:0];
                            state_d     = ST_ISSUE;
                        end
                    end
                    default: ;
                endcase
            end
        end

        // An inactive DM holds everything but dmactive itself at reset values.
        if (!dmactive_d) begin
            data0_d      = 32'd0;
            cmderr_d     = 3'd0;
            resumeack_d  = 1'b0;
            haltreq_d    = 1'b0;
            ndmreset_d   = 1'b0;
            resume_req_d = 1'b0;
            reg_req_d    = 1'b0;
            state_d      = ST_IDLE;
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            state_q      <= ST_IDLE;
            dmi_ack_q    <= 1'b0;
            dmi_rdata_q  <= 32'd0;
            dmi_resp_q   <= 2'd0;
            data0_q      <= 32'd0;
            haltreq_q    <= 1'b0;
            ndmreset_q   <= 1'b0;
            dmactive_q   <= 1'b0;
            resume_req_q <= 1'b0;
            resumeack_q  <= 1'b0;
            cmderr_q     <= 3'd0;
            cmd_write_q  <= 1'b0;
            cmd_regno_q  <= 16'd0;
            reg_req_q    <= 1'b0;
            reg_we_q     <= 1'b0;
            reg_addr_q   <= 16'd0;
            reg_wdata_q  <= 32'd0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            dmi_ack_q    <= dmi_ack_d;
            dmi_rdata_q  <= dmi_rdata_d;
            dmi_resp_q   <= dmi_resp_d;
            data0_q      <= data0_d;
            haltreq_q    <= haltreq_d;
            ndmreset_q   <= ndmreset_d;
            dmactive_q   <= dmactive_d;
            resume_req_q <= resume_req_d;
            resumeack_q  <= resumeack_d;
            cmderr_q     <= cmderr_d;
            cmd_write_q  <= cmd_write_d;
            cmd_regno_q  <= cmd_regno_d;
            reg_req_q    <= reg_req_d;
            reg_we_q     <= reg_we_d;
            reg_addr_q   <= reg_addr_d;
            reg_wdata_q  <= reg_wdata_d;
            cnt_q        <= cnt_d;
        end
    end

    assign dmi_ack    = dmi_ack_q;
    assign dmi_rdata  = dmi_rdata_q;
    assign dmi_resp   = dmi_resp_q;
    assign halt_req   = dmactive_q & haltreq_q;
    assign resume_req = resume_req_q;
    assign reg_req    = reg_req_q;
    assign reg_we     = reg_we_q;
    assign reg_addr   = reg_addr_q;
    assign reg_wdata  = reg_wdata_q;

endmodule

// File: doc/dmi_debug_module.md
Name: dmi_debug_module

Overview:
- DMI responder (Debug Module target) at the far end of the DTM's DMI initiator port.
- Decodes 7-bit DMI accesses into a minimal RISC-V-style Debug Module: data0, dmcontrol, dmstatus, abstractcs and command.
- Drives halt/resume requests to the CPU.
- Runs an abstract-command FSM that reads and writes CPU registers over a simple req/ack port.

Parameters:
- ABITS, 7, DMI address width; must equal the DTM abits field.
- DM_VERSION, 2, dmstatus.version value.
- REG_TIMEOUT, 255, maximum cycles to wait for reg_ack before aborting with cmderr=7.

Ports:
- clk  in  1  block clock; the same domain as the DTM DMI side.
- rst  in  1  reset, asynchronous, active-high.
- dmi_addr  in  ABITS  register address.
- dmi_wdata  in  32  write data.
- dmi_op  in  2  operation: 0=nop, 1=read, 2=write, 3=reserved.
- dmi_req  in  1  request strobe from the DTM.
- dmi_rdata  out  32  read data.
- dmi_resp  out  2  response: 0=OK, 2=failed.
- dmi_ack  out  1  one-cycle completion pulse.
- halted  in  1  CPU is in debug-halt state.
- halt_req  out  1  halt request level to the CPU.
- resume_req  out  1  resume request to the CPU.
- reg_req  out  1  CPU register access request.
- reg_we  out  1  1 = write.
- reg_addr  out  16  regno.
- reg_wdata  out  32  register write data (taken from data0).
- reg_rdata  in  32  register read data.
- reg_ack  in  1  register access complete.

Behaviour:
- Reset: all outputs 0; data0=0, dmcontrol=0, cmderr=0, resumeack=0; abstract FSM in IDLE.
- DMI handshake:
  - A request is sampled on the rising edge of clk when dmi_req=1 and dmi_ack=0.
  - dmi_ack pulses high for exactly one cycle, on the next cycle.
  - dmi_rdata/dmi_resp are valid with dmi_ack; dmi_rdata holds until the next read ack.
  - Write and nop acks leave dmi_rdata unchanged.
  - A request with dmi_ack=1 is ignored; the DTM must drop dmi_req after ack.
  - op=0: ack with resp=0, no side effects.
  - op=3: ack with resp=2'b10, no side effects.
- Register map:
  - 0x04 data0: RW. A write while busy is ignored and sets cmderr=1 if cmderr was 0.
  - 0x10 dmcontrol: bit31 haltreq, bit30 resumereq (write-only, reads 0), bit1 ndmreset, bit0 dmactive.
  - 0x11 dmstatus: RO.
    - [3:0]=DM_VERSION.
    - [7]=1 (authenticated).
    - [8],[9]=halted.
    - [10],[11]=~halted.
    - [16],[17]=resumeack.
  - 0x16 abstractcs:
    - [3:0]=1 (datacount); [28:24]=0 (progbufsize).
    - [12]=busy.
    - [10:8]=cmderr, write-1-to-clear per bit.
    - A write while busy sets cmderr=1 instead of clearing.
  - 0x17 command: WO, reads 0.
  - Unmapped addresses: read 0, write ignored, resp=0.
- dmactive=0: data0, cmderr, resumeack and all dmcontrol bits except dmactive are held at reset values. The FSM is forced to IDLE and reg_req is dropped. The DMI interface remains responsive.
- Run control:
  - halt_req = dmactive & haltreq.
  - Writing resumereq=1 with haltreq=0 sets resume_req=1 and clears resumeack.
  - When resume_req=1 and halted=0, the next cycle sets resume_req=0 and resumeack=1.
  - resumereq=1 together with haltreq=1 is ignored.
- Abstract FSM: IDLE -> ISSUE -> WAIT -> IDLE.
  - A command write in IDLE with cmderr!=0 is ignored.
  - If cmdtype[31:24]!=0 or aarsize[22:20]!=2, set cmderr=2 and stay in IDLE.
  - Else if transfer[17]=1 and halted=0, set cmderr=4 and stay in IDLE.
  - Else if transfer=0, complete immediately: no busy, no reg traffic.
  - Else go to ISSUE, busy=1.
  - ISSUE: reg_req=1, reg_we=write[16], reg_addr=regno[15:0], reg_wdata=data0; go to WAIT.
  - WAIT: reg_req held until reg_ack. On reg_ack:
    - drop reg_req;
    - if a read, data0<=reg_rdata;
    - busy=0; go to IDLE.
  - WAIT with no reg_ack after REG_TIMEOUT cycles: drop reg_req, cmderr=7, busy=0, go to IDLE.
  - A command write while busy sets cmderr=1 (if 0) and does not disturb the active access.
  - A reg_ack outside WAIT is ignored.
- Async rst mid-access: all state clears immediately; reg_req deasserts without waiting for ack.

Test Plan:
1. Reset, then read 0x11 -> version 2, authenticated=1, allrunning with halted=0; dmi_ack high exactly one cycle after req.
2. Write 0x10=0x80000001; model sets halted=1 -> halt_req=1, dmstatus bits 9:8=11. Then write 0x10=0x40000001 and drop halted -> resume_req pulses; dmstatus[17:16]=11.
3. Halted. Write data0=0xCAFEBABE, then command=0x00231008 -> reg_req, reg_we=1, reg_addr=0x1008, reg_wdata=0xCAFEBABE. Model acks after 5 cycles -> abstractcs busy 1 then 0, cmderr=0.
4. Halted. Command=0x00221005, model returns 0x12345678 -> data0 reads 0x12345678. Second command while busy -> cmderr=1. Write abstractcs 0x700 after done -> cmderr=0.
5. Running (halted=0), command=0x00221005 -> cmderr=4, no reg_req. Cmdtype=1 -> cmderr=2. Halted with no reg_ack -> cmderr=7 after 255 cycles.
6. op=3 -> resp=2. Unmapped 0x7F reads 0. Write dmactive=0 -> data0 and cmderr clear. Assert rst during WAIT -> reg_req=0 immediately.
